// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared constants and helpers for the mux_arb_pipe block.
//   MODE_FIXED / MODE_RR : values of the mode input
//   N_MIN / N_MAX        : legal channel-count range
//   wrap_add()           : (base + off) mod n, used for round-robin indexing
package mux_arb_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int N_MIN = 2;
  localparam int N_MAX = 16;

  function automatic int wrap_add(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/mux_arb_pipe_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
// Searches req starting at ptr and wrapping mod N; the first set bit wins.
// Ports:
//   req   [N-1:0]      request vector
//   ptr   [SEL_W-1:0]  highest-priority channel this cycle (0..N-1)
//   grant [N-1:0]      one-hot grant (all zero when no request)
//   idx   [SEL_W-1:0]  index of the granted channel (0 when no request)
module rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] idx
);

  logic found;

  always_comb begin
    int c;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < N; k++) begin
      c = wrap_add(int'(ptr), k, N);
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = SEL_W'(c);
      end
    end
  end

endmodule

// File: rtl/mux_arb_pipe.sv
// mux_arb_pipe: N-channel valid/ready mux with a one-entry registered output.
// Channel selection is either fixed (s) or round-robin (mode). A word accepted
// on an input appears on y with y_valid one cycle later; the output register
// reloads in the same cycle it is taken, giving full throughput.
// Optional feature: define MUX_ARB_PIPE_XFER_CNT_EN to build the 32-bit
// completed-output counter on xfer_cnt; otherwise xfer_cnt is tied to 0.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   a [N*WIDTH-1:0]    channel data, channel i at [i*WIDTH +: WIDTH]
//   a_valid / a_ready  per-channel handshake (a_ready is combinational)
//   s                  channel select in fixed mode
//   mode               0 = fixed, 1 = round-robin
//   y, y_valid, y_ready, y_src  registered output word, handshake, source index
//   xfer_cnt           completed output transfers
module mux_arb_pipe
  import mux_arb_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   a,
  input  logic [N-1:0]         a_valid,
  output logic [N-1:0]         a_ready,
  input  logic [SEL_W-1:0]     s,
  input  logic                 mode,
  output logic [WIDTH-1:0]     y,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic [SEL_W-1:0]     y_src,
  output logic [31:0]          xfer_cnt
);

  logic             load_en;
  logic [SEL_W-1:0] ptr;
  logic [N-1:0]     rr_grant;
  logic [SEL_W-1:0] rr_idx;
  logic [N-1:0]     sel_oh;
  logic [SEL_W-1:0] sel_idx;
  logic [WIDTH-1:0] sel_data;
  logic             take;

  assign load_en = !y_valid || y_ready;

  rr_arbiter #(.N(N)) u_rr_arbiter (
    .req   (a_valid),
    .ptr   (ptr),
    .grant (rr_grant),
    .idx   (rr_idx)
  );

  // Fixed mode offers the slot to channel s whether or not it is valid;
  // round-robin only offers it to the winning valid channel.
  always_comb begin
    sel_oh  = '0;
    sel_idx = '0;
    if (mode == MODE_RR) begin
      sel_oh  = rr_grant;
      sel_idx = rr_idx;
    end else if (int'(s) < N) begin
      sel_oh[s] = 1'b1;
      sel_idx   = s;
    end
  end

  // rst_n gating: during reset y_valid is 0 so load_en alone would be 1.
  assign a_ready = (rst_n && load_en) ? sel_oh : '0;
  assign take    = |(a_ready & a_valid);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_oh[i]) sel_data = a[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y       <= '0;
      y_valid <= 1'b0;
      y_src   <= '0;
      ptr     <= '0;
    end else begin
      if (take) begin
        y       <= sel_data;
        y_src   <= sel_idx;
        y_valid <= 1'b1;
        if (mode == MODE_RR) ptr <= SEL_W'(wrap_add(int'(sel_idx), 1, N));
      end else if (y_ready) begin
        y_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_ARB_PIPE_XFER_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt_q <= '0;
    else if (y_valid && y_ready) cnt_q <= cnt_q + 32'd1;
  end

  assign xfer_cnt = cnt_q;
`else
  assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_mux_arb_pipe.sv
// tb_mux_arb_pipe: randomized + directed scoreboard bench for mux_arb_pipe
// (N=4, WIDTH=32). The stimulus side predicts handshakes from the behavioural
// rules and queues expected output words; a monitor compares what the DUT
// presents on y against the queue.
module tb_mux_arb_pipe;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = 2;

`ifdef MUX_ARB_PIPE_XFER_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] a = '0;
  logic [N-1:0]   a_valid = '0;
  logic [N-1:0]   a_ready;
  logic [SW-1:0]  s = '0;
  logic           mode = 1'b0;
  logic [W-1:0]   y;
  logic           y_valid;
  logic           y_ready = 1'b0;
  logic [SW-1:0]  y_src;
  logic [31:0]    xfer_cnt;

  always #5 clk = ~clk;

  mux_arb_pipe #(.WIDTH(W), .N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .s        (s),
    .mode     (mode),
    .y        (y),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .y_src    (y_src),
    .xfer_cnt (xfer_cnt)
  );

  typedef struct {
    logic [W-1:0]  data;
    logic [SW-1:0] src;
  } word_t;

  int          errors = 0;
  int          checks = 0;
  word_t       exp_q[$];
  int          src_log[$];
  logic        model_full = 1'b0;
  int          model_ptr = 0;
  logic [31:0] model_cnt = '0;
  logic [W-1:0]  last_y = '0;
  logic [SW-1:0] last_src = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus. Inputs change at the falling edge; the model then
  // predicts what the next rising edge does.
  task automatic step(input logic [N*W-1:0] data, input logic [N-1:0] v,
                      input logic [SW-1:0] sel, input logic md, input logic yr);
    logic [N-1:0] er;
    int           g;
    word_t        w;
    @(negedge clk);
    a = data; a_valid = v; s = sel; mode = md; y_ready = yr;
    #1;
    check("y_valid", 64'(y_valid), 64'(model_full));
    check("xfer_cnt", 64'(xfer_cnt), CNT_EN ? 64'(model_cnt) : 64'd0);
    er = '0;
    g  = -1;
    if (!model_full || yr) begin
      if (!md) begin
        er[sel] = 1'b1;
        g = int'(sel);
      end else begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (model_ptr + k) % N;
          if (v[c]) begin
            er[c] = 1'b1;
            g = c;
            break;
          end
        end
      end
    end
    check("a_ready", 64'(a_ready), 64'(er));
    if (model_full && yr) model_cnt++;
    if (g >= 0 && v[g]) begin
      w.data = data[g*W +: W];
      w.src  = SW'(g);
      exp_q.push_back(w);
      model_full = 1'b1;
      if (md) model_ptr = (g + 1) % N;
    end else if (yr) begin
      model_full = 1'b0;
    end
  endtask

  function automatic logic [N*W-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Asynchronous reset pulse placed between clock edges (called right after
  // step, i.e. just past a falling edge); released just after a rising edge.
  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_y", 64'(y), 64'd0);
    check("rst_y_valid", 64'(y_valid), 64'd0);
    check("rst_y_src", 64'(y_src), 64'd0);
    check("rst_a_ready", 64'(a_ready), 64'd0);
    check("rst_xfer_cnt", 64'(xfer_cnt), 64'd0);
    exp_q.delete();
    model_full = 1'b0;
    model_ptr  = 0;
    model_cnt  = '0;
    last_y     = '0;
    last_src   = '0;
    a_valid    = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compare the presented word with the oldest expected one;
  // while y_valid is low, y and y_src must keep the last delivered word.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (y_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL orphan_word: y=0x%0h y_src=%0d with nothing expected", y, y_src);
        end else begin
          check("y", 64'(y), 64'(exp_q[0].data));
          check("y_src", 64'(y_src), 64'(exp_q[0].src));
          if (y_ready) begin
            last_y   = exp_q[0].data;
            last_src = exp_q[0].src;
            src_log.push_back(int'(exp_q[0].src));
            void'(exp_q.pop_front());
          end
        end
      end else begin
        check("y_hold", 64'(y), 64'(last_y));
        check("y_src_hold", 64'(y_src), 64'(last_src));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    int seq_rr[8];
    int seq_13[6];
    logic [N*W-1:0] fixed_data;
    seq_rr = '{0, 1, 2, 3, 0, 1, 2, 3};
    seq_13 = '{1, 3, 1, 3, 1, 3};
    fixed_data = {32'h11, 32'h10, 32'h01, 32'h00};

    // Reset state, with requests present to show a_ready is held low.
    a_valid = '1;
    mode    = 1'b1;
    #3;
    check("init_y", 64'(y), 64'd0);
    check("init_y_valid", 64'(y_valid), 64'd0);
    check("init_y_src", 64'(y_src), 64'd0);
    check("init_a_ready", 64'(a_ready), 64'd0);
    check("init_xfer_cnt", 64'(xfer_cnt), 64'd0);
    a_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fixed mode, S stepping 0..3: Y = 0x00,0x01,0x10,0x11.
    src_log.delete();
    for (int i = 0; i < 4; i++) step(fixed_data, 4'hF, SW'(i), 1'b0, 1'b1);
    step(fixed_data, 4'h0, 2'd0, 1'b0, 1'b1);
    step(fixed_data, 4'h0, 2'd0, 1'b0, 1'b1);
    check("fixed_count", 64'(src_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < src_log.size(); i++)
      check($sformatf("fixed_src[%0d]", i), 64'(src_log[i]), 64'(i));
    check("fixed_last_y", 64'(last_y), 64'h11);

    // Round-robin, all valid: 0,1,2,3,0,1,2,3.
    src_log.delete();
    for (int i = 0; i < 8; i++) step(rand_data(), 4'hF, 2'd0, 1'b1, 1'b1);
    step(rand_data(), 4'h0, 2'd0, 1'b1, 1'b1);
    step(rand_data(), 4'h0, 2'd0, 1'b1, 1'b1);
    check("rr_count", 64'(src_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < src_log.size(); i++)
      check($sformatf("rr_src[%0d]", i), 64'(src_log[i]), 64'(seq_rr[i]));

    // Round-robin, only channels 1 and 3 valid.
    src_log.delete();
    for (int i = 0; i < 6; i++) step(rand_data(), 4'b1010, 2'd0, 1'b1, 1'b1);
    step(rand_data(), 4'h0, 2'd0, 1'b1, 1'b1);
    step(rand_data(), 4'h0, 2'd0, 1'b1, 1'b1);
    check("rr13_count", 64'(src_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < src_log.size(); i++)
      check($sformatf("rr13_src[%0d]", i), 64'(src_log[i]), 64'(seq_13[i]));

    // Output stall for 3 cycles, then release with no bubble.
    step(rand_data(), 4'hF, 2'd0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(rand_data(), 4'hF, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(rand_data(), 4'hF, 2'd0, 1'b1, 1'b1);

    // Reset mid-stream, then round-robin restarts at channel 0 and 10
    // outputs complete.
    pulse_reset();
    src_log.delete();
    for (int i = 0; i < 10; i++) step(rand_data(), 4'hF, 2'd0, 1'b1, 1'b1);
    step(rand_data(), 4'h0, 2'd0, 1'b1, 1'b1);
    step(rand_data(), 4'h0, 2'd0, 1'b1, 1'b1);
    check("post_rst_src0", src_log.size() > 0 ? 64'(src_log[0]) : 64'hFF, 64'd0);
    check("xfer_cnt_10", 64'(xfer_cnt), CNT_EN ? 64'd10 : 64'd0);

    // Randomized traffic with mode / select changes and back-pressure.
    for (int i = 0; i < 400; i++) begin
      logic md;
      md = (i % 50 < 25) ? 1'($urandom_range(0, 1)) : 1'b1;
      step(rand_data(), 4'($urandom), 2'($urandom), md, ($urandom_range(0, 3) != 0));
      if (i == 200) pulse_reset();
    end
    step(rand_data(), 4'h0, 2'd0, 1'b1, 1'b1);
    step(rand_data(), 4'h0, 2'd0, 1'b1, 1'b1);
    check("drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_arb_pipe.md
MUX_ARB_PIPE -- requirements
Module: mux_arb_pipe

Interface
REQ-001 Parameter WIDTH, default 32, data width per channel.
REQ-002 Parameter N, default 4, channel count, legal range 2..16.
REQ-003 Parameter SEL_W, default $clog2(N), select width; derived, never overridden.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-006 A  input  N*WIDTH  channel data, channel i at bits [i*WIDTH +: WIDTH].
REQ-007 A_VALID  input  N  per-channel data valid.
REQ-008 A_READY  output  N  per-channel accept; combinational from state and inputs.
REQ-009 S  input  SEL_W  channel select, used in fixed mode only.
REQ-010 MODE  input  1  0 = fixed select via S, 1 = round-robin.
REQ-011 Y  output  WIDTH  registered selected data.
REQ-012 Y_VALID  output  1  Y holds an untaken word.
REQ-013 Y_READY  input  1  downstream accept.
REQ-014 Y_SRC  output  SEL_W  index of the channel that supplied Y.
REQ-015 XFER_CNT  output  32  accepted-output counter (see Configuration).

Function
REQ-016 Output stage is a one-entry register; load_en = !Y_VALID || Y_READY.
REQ-017 Transfer on channel i when A_VALID[i] && A_READY[i]; at most one A_READY bit high per cycle.
REQ-018 Latency: word accepted in cycle t appears on Y with Y_VALID=1 in cycle t+1.
REQ-019 Fixed mode: A_READY[S] = load_en; all other bits 0; S >= N gives no grant, A_READY all 0.
REQ-020 Round-robin mode: grant first valid channel searching ptr, ptr+1, ... wrapping mod N; A_READY[grant] = load_en.
REQ-021 ptr advances to (grant+1) mod N only on a completed input transfer; ptr unchanged in fixed mode.
REQ-022 While Y_VALID && !Y_READY: Y, Y_SRC, Y_VALID hold stable; no input accepted.
REQ-023 Y_READY with no valid source granted: Y_VALID clears next cycle; Y, Y_SRC hold last value.
REQ-024 Simultaneous output take and input accept in one cycle: new word loads, Y_VALID stays 1 (full throughput).
REQ-025 MODE or S change takes effect the same cycle combinationally on A_READY; an already registered word is unaffected.

Reset
REQ-026 RST_N low asynchronously forces Y=0, Y_VALID=0, Y_SRC=0, ptr=0, XFER_CNT=0.
REQ-027 Reset mid-transfer discards the held word; A_READY all 0 while RST_N low.
REQ-028 First accept possible in the first rising edge after RST_N deasserts.

Configuration
REQ-029 Macro MUX_ARB_PIPE_XFER_CNT_EN defined: XFER_CNT increments by 1 per cycle with Y_VALID && Y_READY, wraps 0xFFFFFFFF -> 0.
REQ-030 Macro undefined: XFER_CNT tied to 0, no counter flops synthesised; all other behaviour identical.

Structure
REQ-031 Package mux_arb_pkg holds MODE constants (MODE_FIXED=0, MODE_RR=1) and N range limits.
REQ-032 Sub-module rr_arbiter (N-bit request, ptr in, one-hot grant + index out) is combinational and instantiated once.

Verification
REQ-033 N=4, WIDTH=32, fixed mode, A={0x11,0x10,0x01,0x00}, all valid, Y_READY=1, S stepping 0..3 each cycle -> Y = 0x00,0x01,0x10,0x11 one cycle later, Y_SRC = S delayed by 1.
REQ-034 RR mode, all 4 valid, Y_READY=1 for 8 cycles -> Y_SRC sequence 0,1,2,3,0,1,2,3; ptr wraps 3->0.
REQ-035 RR mode, only channels 1 and 3 valid -> Y_SRC alternates 1,3,1,3; A_READY[0], A_READY[2] never high.
REQ-036 Y_READY held 0 for 3 cycles with Y_VALID=1 -> Y, Y_SRC unchanged, A_READY all 0; release -> next word loads same cycle, no gap.
REQ-037 RST_N pulsed low mid-stream between clock edges -> Y=0, Y_VALID=0, Y_SRC=0 immediately; after release RR restarts at channel 0.
REQ-038 With MUX_ARB_PIPE_XFER_CNT_EN, 10 completed output transfers -> XFER_CNT=10; without macro -> XFER_CNT=0 throughout.
